cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Execution-side partner of the CPU controller: consumes decoded control word DA/AA/BA/FS/MB/MD/RW/MW and executes it.
- Contains 16x16 register file, 3-bit-FS ALU, status flags, and a handshaked data-memory port.
- Returns busA to the controller's D input (jump/branch target) and asserts stall while a memory access is outstanding.

Parameters:
- busSize, 16, datapath/register width
- addressWidth, 4, register address width (2^addressWidth registers)
- fsWidth, 3, ALU function-select width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- DA  input  addressWidth  destination register
- AA  input  addressWidth  source A register
- BA  input  addressWidth  source B register
- FS  input  fsWidth  ALU function
- MB  input  1  B-operand select: 0=R[BA], 1=constIn
- MD  input  1  writeback select: 0=ALU, 1=memory data
- RW  input  1  register write enable
- MW  input  1  memory write (store)
- constIn  input  busSize  immediate operand
- memRdata  input  busSize  data-memory read data
- memReady  input  1  memory completion, one-cycle pulse
- busA  output  busSize  R[AA], combinational; feeds controller D
- busB  output  busSize  muxed B operand, combinational
- memAddr  output  busSize  registered access address
- memWdata  output  busSize  registered store data
- memRead  output  1  registered load request
- memWrite  output  1  registered store request
- stall  output  1  controller must hold its control word while high
- Z, N, C, V  output  1 each  registered status flags

Behaviour:
- Reset (reset=0, async): all registers and flags 0; memAddr, memWdata = 0; memRead, memWrite, stall = 0; FSM in IDLE.
- Register read: combinational, so a write at edge k is visible on busA/busB after edge k. No bypass is needed.
- ALU FS encoding:
  - 000: A+B
  - 001: A-B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: ~A
  - 110: A<<1
  - 111: A>>1 (logical)
- ALU result is modulo 2^busSize.
- Flags:
  - C is the carry-out for ADD and the NOT-borrow for SUB (A>=B unsigned gives C=1).
  - For shifts, C is the shifted-out bit; for logic ops, C=0.
  - V is two's-complement overflow for ADD/SUB; otherwise V=0.
  - Z and N are taken from the result.
- ALU op:
  - An ALU op is a cycle with RW=1, MD=0, MW=0 in IDLE.
  - R[DA] and the flags are written on the next edge. Latency is 1 cycle, with no stall.
  - When RW=0, flags hold.
- Memory FSM states are IDLE and WAIT.
  - IDLE, load (MD=1, RW=1, MW=0): stall=1 combinationally. On the edge, memAddr is latched from busA, memRead is set to 1, and the FSM enters WAIT.
  - IDLE, store (MW=1): stall=1. On the edge, memAddr is latched from busA, memWdata from busB, memWrite is set to 1, and the FSM enters WAIT. No register write.
  - MW=1 with MD=1: treated as a store; the register write is suppressed.
  - WAIT with memReady=0: stall=1; request and address held.
  - WAIT with memReady=1: stall=0 in that cycle. On the edge, R[DA] is written with memRdata (load only), memRead/memWrite are cleared, and the FSM returns to IDLE. Flags are unchanged by memory ops.
  - memReady in IDLE is ignored.
- Minimum memory op is 2 cycles; the controller holds its control word while stall=1.
- Reset mid-WAIT: request drops immediately and the pending load is discarded.
- RW=0 with MD=1 and MW=0: no-op, no memory access.
- DA=AA on an ALU op: reads the old value and writes the new value on the edge.

Decomposition:
- Shared package holds:
  - FS opcode constants (FS_ADD..FS_SHR)
  - FSM state encoding (ST_IDLE, ST_WAIT)
  - busSize/addressWidth constants shared with cpuController
- Natural sub-module: register_file (2 combinational read ports, 1 synchronous write port, async active-low clear).
- ALU and memory FSM stay inline.

Test Plan:
- Reset then ALU ADD:
  - Stimulus: write R1=0x7FFF, R2=0x0001 via MB=1 constant ADD from R0, then FS=000, AA=1, BA=2, DA=3, RW=1.
  - Response: R3=0x8000, N=1, V=1, C=0, Z=0.
- SUB equal:
  - Stimulus: R4=0x1234, FS=001, AA=4, BA=4, DA=5.
  - Response: R5=0, Z=1, C=1, V=0.
- Load with 3-cycle latency:
  - Stimulus: R6=0x0040, MD=1, RW=1, AA=6, DA=7; memReady pulses 3 cycles after memRead; memRdata=0xBEEF.
  - Response: memAddr=0x0040; stall high until the memReady cycle; R7=0xBEEF; flags unchanged.
- Store:
  - Stimulus: MW=1, AA=6, BA=7, memReady after 1 cycle.
  - Response: memWrite=1, memAddr=0x0040, memWdata=0xBEEF; no register changes.
- Reset mid-WAIT:
  - Stimulus: start a load, assert reset=0 while in WAIT.
  - Response: memRead=0 and stall=0 immediately; all registers 0; a later memReady is ignored.
- Shift carry:
  - Stimulus: R8=0x8001, FS=110, then FS=111.
  - Response: 0x0002 with C=1, then 0x4000 with C=1.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the CPU datapath and its controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: bus/address/function-select widths, ALU opcodes, memory FSM states.
package cpu_datapath_pkg;

  localparam int BUS_SIZE   = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int FS_WIDTH   = 3;

  // ALU function-select encodings
  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_AND = 3'b010;
  localparam logic [2:0] FS_OR  = 3'b011;
  localparam logic [2:0] FS_XOR = 3'b100;
  localparam logic [2:0] FS_NOT = 3'b101;
  localparam logic [2:0] FS_SHL = 3'b110;
  localparam logic [2:0] FS_SHR = 3'b111;

  // Memory access FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/cpu_datapath_register_file.sv
// Register file: 2 combinational read ports, 1 synchronous write port.
// Latency: reads are combinational; a write at edge k is visible right after edge k.
// Backpressure: none, writes are always accepted.
// Ports: clk/rst_n, ra_addr/ra_dat and rb_addr/rb_dat read ports, we/wa/wd write port.
module cpu_datapath_register_file
  import cpu_datapath_pkg::*;
#(
  parameter int dataWidth = BUS_SIZE,
  parameter int addrWidth = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [addrWidth-1:0] ra_addr,
  input  logic [addrWidth-1:0] rb_addr,
  output logic [dataWidth-1:0] ra_dat,
  output logic [dataWidth-1:0] rb_dat,
  input  logic                 we,
  input  logic [addrWidth-1:0] wa,
  input  logic [dataWidth-1:0] wd
);

  localparam int NumRegs = 2 ** addrWidth;

  logic [dataWidth-1:0] regs_q [NumRegs];
  logic [dataWidth-1:0] regs_d [NumRegs];

  assign ra_dat = regs_q[ra_addr];
  assign rb_dat = regs_q[rb_addr];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: executes the decoded control word (ALU op, load or store).
// Latency: ALU op writes R[DA]/flags on the next edge; memory ops take >= 2 cycles.
// Backpressure: stall is high while a memory access is outstanding; the controller holds its word.
// Ports: control word DA/AA/BA/FS/MB/MD/RW/MW + constIn; busA/busB operand buses;
//        memAddr/memWdata/memRead/memWrite request, memRdata/memReady response; Z/N/C/V flags.
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int busSize      = BUS_SIZE,
  parameter int addressWidth = ADDR_WIDTH,
  parameter int fsWidth      = FS_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addressWidth-1:0] DA,
  input  logic [addressWidth-1:0] AA,
  input  logic [addressWidth-1:0] BA,
  input  logic [fsWidth-1:0]      FS,
  input  logic                    MB,
  input  logic                    MD,
  input  logic                    RW,
  input  logic                    MW,
  input  logic [busSize-1:0]      constIn,
  input  logic [busSize-1:0]      memRdata,
  input  logic                    memReady,
  output logic [busSize-1:0]      busA,
  output logic [busSize-1:0]      busB,
  output logic [busSize-1:0]      memAddr,
  output logic [busSize-1:0]      memWdata,
  output logic                    memRead,
  output logic                    memWrite,
  output logic                    stall,
  output logic                    Z,
  output logic                    N,
  output logic                    C,
  output logic                    V
);

  localparam int Msb = busSize - 1;

  logic [0:0]         state_q, state_d;
  logic [busSize-1:0] mem_addr_q, mem_addr_d;
  logic [busSize-1:0] mem_wdata_q, mem_wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [3:0]         flags_q, flags_d;  // {Z, N, C, V}

  logic [busSize-1:0] rb_dat;
  logic               rf_we;
  logic [busSize-1:0] rf_wd;

  logic [busSize:0]   alu_ext;
  logic [busSize-1:0] alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               stall_raw;

  cpu_datapath_register_file #(
    .dataWidth(busSize),
    .addrWidth(addressWidth)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .ra_addr (AA),
    .rb_addr (BA),
    .ra_dat  (busA),
    .rb_dat  (rb_dat),
    .we      (rf_we),
    .wa      (DA),
    .wd      (rf_wd)
  );

  assign busB = MB ? constIn : rb_dat;

  // ALU: one extra bit on add/sub captures carry / borrow
  always_comb begin
    alu_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (FS)
      FS_ADD: begin
        alu_ext = {1'b0, busA} + {1'b0, busB};
        alu_res = alu_ext[busSize-1:0];
        alu_c   = alu_ext[busSize];
        alu_v   = (busA[Msb] == busB[Msb]) && (alu_res[Msb] != busA[Msb]);
      end
      FS_SUB: begin
        alu_ext = {1'b0, busA} - {1'b0, busB};
        alu_res = alu_ext[busSize-1:0];
        alu_c   = ~alu_ext[busSize];  // carry = NOT borrow, so A>=B gives 1
        alu_v   = (busA[Msb] != busB[Msb]) && (alu_res[Msb] != busA[Msb]);
      end
      FS_AND: alu_res = busA & busB;
      FS_OR:  alu_res = busA | busB;
      FS_XOR: alu_res = busA ^ busB;
      FS_NOT: alu_res = ~busA;
      FS_SHL: begin
        alu_res = {busA[busSize-2:0], 1'b0};
        alu_c   = busA[Msb];
      end
      FS_SHR: begin
        alu_res = {1'b0, busA[busSize-1:1]};
        alu_c   = busA[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Memory FSM and writeback selection
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    flags_d     = flags_q;
    rf_we       = 1'b0;
    rf_wd       = alu_res;
    stall_raw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MW) begin
          // Store wins over MD; no register write
          stall_raw   = 1'b1;
          mem_addr_d  = busA;
          mem_wdata_d = busB;
          mem_write_d = 1'b1;
          state_d     = ST_WAIT;
        end else if (MD && RW) begin
          stall_raw  = 1'b1;
          mem_addr_d = busA;
          mem_read_d = 1'b1;
          state_d    = ST_WAIT;
        end else if (RW && !MD) begin
          rf_we   = 1'b1;
          rf_wd   = alu_res;
          flags_d = {(alu_res == '0), alu_res[Msb], alu_c, alu_v};
        end
      end
      ST_WAIT: begin
        if (memReady) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_IDLE;
          if (mem_read_q) begin
            rf_we = 1'b1;
            rf_wd = memRdata;
          end
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall must drop as soon as reset asserts, even with a mem op on the inputs
  assign stall = stall_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      flags_q     <= flags_d;
    end
  end

  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memRead  = mem_read_q;
  assign memWrite = mem_write_q;
  assign {Z, N, C, V} = flags_q;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  DA, AA, BA;
  logic [2:0]  FS;
  logic        MB, MD, RW, MW;
  logic [15:0] constIn, memRdata;
  logic        memReady;
  logic [15:0] busA, busB, memAddr, memWdata;
  logic        memRead, memWrite, stall, Z, N, C, V;

  cpu_datapath dut (
    .clk(clk), .reset(reset), .DA(DA), .AA(AA), .BA(BA), .FS(FS),
    .MB(MB), .MD(MD), .RW(RW), .MW(MW), .constIn(constIn),
    .memRdata(memRdata), .memReady(memReady), .busA(busA), .busB(busB),
    .memAddr(memAddr), .memWdata(memWdata), .memRead(memRead),
    .memWrite(memWrite), .stall(stall), .Z(Z), .N(N), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  // Behavioural model state
  logic [15:0] m_reg [16];
  logic        m_z, m_n, m_c, m_v;
  bit          m_busy, m_load, m_rd, m_wr;
  logic [15:0] m_addr, m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_busb();
    return MB ? constIn : m_reg[BA];
  endfunction

  function automatic logic exp_stall();
    if (!reset) return 1'b0;
    if (!m_busy) return MW || (MD && RW);
    return !memReady;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    {m_z, m_n, m_c, m_v} = 4'b0;
    m_busy = 0; m_load = 0; m_rd = 0; m_wr = 0;
    m_addr = 16'h0; m_wdata = 16'h0;
  endtask

  task automatic model_step();
    int unsigned a, b, res;
    int sa, sb, sv;
    bit c, v;
    if (!m_busy) begin
      if (MW) begin
        m_addr = m_reg[AA]; m_wdata = exp_busb(); m_wr = 1; m_busy = 1; m_load = 0;
      end else if (MD && RW) begin
        m_addr = m_reg[AA]; m_rd = 1; m_busy = 1; m_load = 1;
      end else if (RW) begin
        a = m_reg[AA]; b = exp_busb();
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        c = 0; v = 0; res = 0;
        case (FS)
          3'd0: begin res = (a + b) % 65536; c = (a + b) > 65535;
                      sv = sa + sb; v = (sv > 32767) || (sv < -32768); end
          3'd1: begin res = (a + 65536 - b) % 65536; c = (a >= b);
                      sv = sa - sb; v = (sv > 32767) || (sv < -32768); end
          3'd2: res = a & b;
          3'd3: res = a | b;
          3'd4: res = a ^ b;
          3'd5: res = 65535 - a;
          3'd6: begin res = (a * 2) % 65536; c = (a / 32768) != 0; end
          default: begin res = a / 2; c = (a % 2) != 0; end
        endcase
        m_reg[DA] = res[15:0];
        m_z = (res == 0); m_n = (res >= 32768); m_c = c; m_v = v;
      end
    end else if (memReady) begin
      if (m_load) m_reg[DA] = memRdata;
      m_rd = 0; m_wr = 0; m_busy = 0;
    end
  endtask

  // Cycle-by-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("busA", busA, m_reg[AA]);
      chk("busB", busB, exp_busb());
      chk("stall", stall, exp_stall());
      chk("memRead", memRead, m_rd);
      chk("memWrite", memWrite, m_wr);
      chk("memAddr", memAddr, m_addr);
      chk("memWdata", memWdata, m_wdata);
      chk("flags", {Z, N, C, V}, {m_z, m_n, m_c, m_v});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic ctl(input logic [3:0] da, input logic [3:0] aa, input logic [3:0] ba,
                     input logic [2:0] fs, input logic mb, input logic md,
                     input logic rw, input logic mw, input logic [15:0] k);
    DA = da; AA = aa; BA = ba; FS = fs; MB = mb; MD = md; RW = rw; MW = mw; constIn = k;
  endtask

  task automatic nop(input logic [3:0] aa);
    ctl(4'd0, aa, 4'd0, FS_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic random_word();
    int sel;
    sel = $urandom_range(0, 9);
    DA = 4'($urandom); AA = 4'($urandom); BA = 4'($urandom); FS = 3'($urandom);
    MB = 1'($urandom);
    case ($urandom_range(0, 3))
      0: constIn = 16'h7FFF;
      1: constIn = 16'h8000;
      2: constIn = 16'hFFFF;
      default: constIn = 16'($urandom);
    endcase
    if (sel < 6)       begin RW = 1; MD = 0; MW = 0; end
    else if (sel == 6) begin RW = 1; MD = 1; MW = 0; end
    else if (sel == 7) begin RW = 1'($urandom); MD = 1'($urandom); MW = 1; end
    else if (sel == 8) begin RW = 0; MD = 1; MW = 0; end
    else               begin RW = 0; MD = 0; MW = 0; end
  endtask

  initial begin
    reset = 1'b0; memReady = 1'b0; memRdata = 16'h0;
    nop(4'd0);
    model_reset();
    #12;
    chk("rst_memAddr", memAddr, 16'h0);
    chk("rst_memRead", memRead, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_flags", {Z, N, C, V}, 4'b0);
    reset = 1'b1;
    check_en = 1;
    tick();

    // ADD overflow: 0x7FFF + 0x0001
    ctl(4'd1, 4'd0, 4'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7FFF); tick();
    ctl(4'd2, 4'd0, 4'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001); tick();
    ctl(4'd3, 4'd1, 4'd2, FS_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
    nop(4'd3); #1;
    chk("add_r3", busA, 16'h8000);
    chk("add_flags", {Z, N, C, V}, 4'b0101);

    // SUB equal operands
    ctl(4'd4, 4'd0, 4'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234); tick();
    ctl(4'd6, 4'd0, 4'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040); tick();
    ctl(4'd5, 4'd4, 4'd4, FS_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
    nop(4'd5); #1;
    chk("sub_r5", busA, 16'h0000);
    chk("sub_flags", {Z, N, C, V}, 4'b1010);

    // Load, memReady three cycles after memRead
    ctl(4'd7, 4'd6, 4'd0, FS_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0); #1;
    chk("ld_stall_idle", stall, 1'b1);
    tick();
    chk("ld_memRead", memRead, 1'b1);
    chk("ld_memAddr", memAddr, 16'h0040);
    tick(); tick();
    chk("ld_stall_wait", stall, 1'b1);
    memReady = 1'b1; memRdata = 16'hBEEF; #1;
    chk("ld_stall_ready", stall, 1'b0);
    tick();
    memReady = 1'b0; nop(4'd7); #1;
    chk("ld_r7", busA, 16'hBEEF);
    chk("ld_memRead_clr", memRead, 1'b0);
    chk("ld_flags_held", {Z, N, C, V}, 4'b1010);

    // Store
    ctl(4'd0, 4'd6, 4'd7, FS_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0); #1;
    chk("st_stall", stall, 1'b1);
    tick();
    chk("st_memWrite", memWrite, 1'b1);
    chk("st_memAddr", memAddr, 16'h0040);
    chk("st_memWdata", memWdata, 16'hBEEF);
    memReady = 1'b1; #1;
    chk("st_stall_ready", stall, 1'b0);
    tick();
    memReady = 1'b0; nop(4'd7); #1;
    chk("st_memWrite_clr", memWrite, 1'b0);
    chk("st_r7_kept", busA, 16'hBEEF);

    // Shift carry-out
    ctl(4'd8, 4'd0, 4'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001); tick();
    ctl(4'd9, 4'd8, 4'd0, FS_SHL, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
    nop(4'd9); #1;
    chk("shl_r9", busA, 16'h0002);
    chk("shl_c", C, 1'b1);
    ctl(4'd10, 4'd8, 4'd0, FS_SHR, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0); tick();
    nop(4'd10); #1;
    chk("shr_r10", busA, 16'h4000);
    chk("shr_c", C, 1'b1);

    // Reset while a load is waiting
    ctl(4'd11, 4'd6, 4'd0, FS_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0); tick();
    chk("rw_memRead", memRead, 1'b1);
    #1 reset = 1'b0; model_reset();
    #1;
    chk("rw_memRead_drop", memRead, 1'b0);
    chk("rw_stall_drop", stall, 1'b0);
    tick();
    #2 reset = 1'b1;
    nop(4'd0); memReady = 1'b1; memRdata = 16'h5A5A;
    tick();
    memReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      AA = 4'(i); #1;
      chk("rw_reg_clear", busA, 16'h0);
    end
    chk("rw_memRead_idle", memRead, 1'b0);

    // Randomized traffic; the controller holds its word while a request is outstanding
    for (int n = 0; n < 3000; n++) begin
      if (!m_busy) random_word();
      memReady = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      memRdata = 16'($urandom);
      tick();
    end

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
